zero_encode: RTL and testbench

//  CAVLC encoder stage: emits the total_zeros codeword, then run_before codewords, for one residual block.

---
 rtl/zero_encode.sv | 370 +++++++++++++++++++++++++++++++++++++
 tb/tb_zero_encode.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_encode.sv
// zero_encode: CAVLC total_zeros / run_before codeword generator.
// Emits one codeword per valid/ready handshake toward the packer.
module zero_encode #(
  parameter int MAX_COEFF = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  TotalCoeff,
  input  logic [3:0]  TotalZeroes,
  input  logic [63:0] RunBefore,
  output logic [10:0] CodeBits,
  output logic [3:0]  CodeLen,
  output logic        CodeValid,
  input  logic        CodeReady,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam logic [4:0] MAXC = 5'(MAX_COEFF);

  typedef enum logic [1:0] {
    IDLE,
    TOTAL_ZERO,
    ZERO_RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [4:0]  tc;
  logic [3:0]  tz;
  logic [63:0] runs;
  logic [3:0]  zl;
  logic [3:0]  idx;
  logic        err;

  logic [3:0]  run;
  logic [3:0]  r;
  logic        clamp;
  logic        tz_bad;
  logic        hs;
  logic        last_run;
  logic [2:0]  ctx;
  logic [14:0] tz_cw;
  logic [14:0] rb_cw;

  // {len, bits} for total_zeros, 4x4 tables indexed by TotalCoeff
  function automatic logic [14:0] tz_code(
    input logic [4:0] c_tc,
    input logic [3:0] c_tz
  );
    logic [14:0] c;
    c = {4'd1, 11'd0};
    case (c_tc)
      5'd1: case (c_tz)
        4'd0:  c = {4'd1, 11'b1};
        4'd1:  c = {4'd3, 11'b011};
        4'd2:  c = {4'd3, 11'b010};
        4'd3:  c = {4'd4, 11'b0011};
        4'd4:  c = {4'd4, 11'b0010};
        4'd5:  c = {4'd5, 11'b00011};
        4'd6:  c = {4'd5, 11'b00010};
        4'd7:  c = {4'd6, 11'b000011};
        4'd8:  c = {4'd6, 11'b000010};
        4'd9:  c = {4'd7, 11'b0000011};
        4'd10: c = {4'd7, 11'b0000010};
        4'd11: c = {4'd8, 11'b00000011};
        4'd12: c = {4'd8, 11'b00000010};
        4'd13: c = {4'd9, 11'b000000011};
        4'd14: c = {4'd9, 11'b000000010};
        default: c = {4'd9, 11'b000000001};
      endcase
      5'd2: case (c_tz)
        4'd0:  c = {4'd3, 11'b111};
        4'd1:  c = {4'd3, 11'b110};
        4'd2:  c = {4'd3, 11'b101};
        4'd3:  c = {4'd3, 11'b100};
        4'd4:  c = {4'd3, 11'b011};
        4'd5:  c = {4'd4, 11'b0101};
        4'd6:  c = {4'd4, 11'b0100};
        4'd7:  c = {4'd4, 11'b0011};
        4'd8:  c = {4'd4, 11'b0010};
        4'd9:  c = {4'd5, 11'b00011};
        4'd10: c = {4'd5, 11'b00010};
        4'd11: c = {4'd6, 11'b000011};
        4'd12: c = {4'd6, 11'b000010};
        4'd13: c = {4'd6, 11'b000001};
        4'd14: c = {4'd6, 11'b000000};
        default: ;
      endcase
      5'd3: case (c_tz)
        4'd0:  c = {4'd4, 11'b0101};
        4'd1:  c = {4'd3, 11'b111};
        4'd2:  c = {4'd3, 11'b110};
        4'd3:  c = {4'd3, 11'b101};
        4'd4:  c = {4'd4, 11'b0100};
        4'd5:  c = {4'd4, 11'b0011};
        4'd6:  c = {4'd3, 11'b100};
        4'd7:  c = {4'd3, 11'b011};
        4'd8:  c = {4'd4, 11'b0010};
        4'd9:  c = {4'd5, 11'b00011};
        4'd10: c = {4'd5, 11'b00010};
        4'd11: c = {4'd6, 11'b000001};
        4'd12: c = {4'd5, 11'b00001};
        4'd13: c = {4'd6, 11'b000000};
        default: ;
      endcase
      5'd4: case (c_tz)
        4'd0:  c = {4'd5, 11'b00011};
        4'd1:  c = {4'd3, 11'b111};
        4'd2:  c = {4'd4, 11'b0101};
        4'd3:  c = {4'd4, 11'b0100};
        4'd4:  c = {4'd3, 11'b110};
        4'd5:  c = {4'd3, 11'b101};
        4'd6:  c = {4'd3, 11'b100};
        4'd7:  c = {4'd4, 11'b0011};
        4'd8:  c = {4'd3, 11'b011};
        4'd9:  c = {4'd4, 11'b0010};
        4'd10: c = {4'd5, 11'b00010};
        4'd11: c = {4'd5, 11'b00001};
        4'd12: c = {4'd5, 11'b00000};
        default: ;
      endcase
      5'd5: case (c_tz)
        4'd0:  c = {4'd4, 11'b0101};
        4'd1:  c = {4'd4, 11'b0100};
        4'd2:  c = {4'd4, 11'b0011};
        4'd3:  c = {4'd3, 11'b111};
        4'd4:  c = {4'd3, 11'b110};
        4'd5:  c = {4'd3, 11'b101};
        4'd6:  c = {4'd3, 11'b100};
        4'd7:  c = {4'd3, 11'b011};
        4'd8:  c = {4'd4, 11'b0010};
        4'd9:  c = {4'd5, 11'b00001};
        4'd10: c = {4'd4, 11'b0001};
        4'd11: c = {4'd5, 11'b00000};
        default: ;
      endcase
      5'd6: case (c_tz)
        4'd0:  c = {4'd6, 11'b000001};
        4'd1:  c = {4'd5, 11'b00001};
        4'd2:  c = {4'd3, 11'b111};
        4'd3:  c = {4'd3, 11'b110};
        4'd4:  c = {4'd3, 11'b101};
        4'd5:  c = {4'd3, 11'b100};
        4'd6:  c = {4'd3, 11'b011};
        4'd7:  c = {4'd3, 11'b010};
        4'd8:  c = {4'd4, 11'b0001};
        4'd9:  c = {4'd3, 11'b001};
        4'd10: c = {4'd6, 11'b000000};
        default: ;
      endcase
      5'd7: case (c_tz)
        4'd0:  c = {4'd6, 11'b000001};
        4'd1:  c = {4'd5, 11'b00001};
        4'd2:  c = {4'd3, 11'b101};
        4'd3:  c = {4'd3, 11'b100};
        4'd4:  c = {4'd3, 11'b011};
        4'd5:  c = {4'd2, 11'b11};
        4'd6:  c = {4'd3, 11'b010};
        4'd7:  c = {4'd4, 11'b0001};
        4'd8:  c = {4'd3, 11'b001};
        4'd9:  c = {4'd6, 11'b000000};
        default: ;
      endcase
      5'd8: case (c_tz)
        4'd0:  c = {4'd6, 11'b000001};
        4'd1:  c = {4'd4, 11'b0001};
        4'd2:  c = {4'd5, 11'b00001};
        4'd3:  c = {4'd3, 11'b011};
        4'd4:  c = {4'd2, 11'b11};
        4'd5:  c = {4'd2, 11'b10};
        4'd6:  c = {4'd3, 11'b010};
        4'd7:  c = {4'd3, 11'b001};
        4'd8:  c = {4'd6, 11'b000000};
        default: ;
      endcase
      5'd9: case (c_tz)
        4'd0:  c = {4'd6, 11'b000001};
        4'd1:  c = {4'd6, 11'b000000};
        4'd2:  c = {4'd4, 11'b0001};
        4'd3:  c = {4'd2, 11'b11};
        4'd4:  c = {4'd2, 11'b10};
        4'd5:  c = {4'd3, 11'b001};
        4'd6:  c = {4'd2, 11'b01};
        4'd7:  c = {4'd5, 11'b00001};
        default: ;
      endcase
      5'd10: case (c_tz)
        4'd0:  c = {4'd5, 11'b00001};
        4'd1:  c = {4'd5, 11'b00000};
        4'd2:  c = {4'd3, 11'b001};
        4'd3:  c = {4'd2, 11'b11};
        4'd4:  c = {4'd2, 11'b10};
        4'd5:  c = {4'd2, 11'b01};
        4'd6:  c = {4'd4, 11'b0001};
        default: ;
      endcase
      5'd11: case (c_tz)
        4'd0:  c = {4'd4, 11'b0000};
        4'd1:  c = {4'd4, 11'b0001};
        4'd2:  c = {4'd3, 11'b001};
        4'd3:  c = {4'd3, 11'b010};
        4'd4:  c = {4'd1, 11'b1};
        4'd5:  c = {4'd3, 11'b011};
        default: ;
      endcase
      5'd12: case (c_tz)
        4'd0:  c = {4'd4, 11'b0000};
        4'd1:  c = {4'd4, 11'b0001};
        4'd2:  c = {4'd2, 11'b01};
        4'd3:  c = {4'd1, 11'b1};
        4'd4:  c = {4'd3, 11'b001};
        default: ;
      endcase
      5'd13: case (c_tz)
        4'd0:  c = {4'd3, 11'b000};
        4'd1:  c = {4'd3, 11'b001};
        4'd2:  c = {4'd1, 11'b1};
        4'd3:  c = {4'd2, 11'b01};
        default: ;
      endcase
      5'd14: case (c_tz)
        4'd0:  c = {4'd2, 11'b00};
        4'd1:  c = {4'd2, 11'b01};
        4'd2:  c = {4'd1, 11'b1};
        default: ;
      endcase
      5'd15: case (c_tz)
        4'd0:  c = {4'd1, 11'b0};
        4'd1:  c = {4'd1, 11'b1};
        default: ;
      endcase
      default: ;
    endcase
    return c;
  endfunction

  // {len, bits} for run_before; context 7 stands for ZeroesLeft > 6
  function automatic logic [14:0] rb_code(
    input logic [2:0] c_ctx,
    input logic [3:0] c_r
  );
    logic [14:0] c;
    c = {4'd1, 11'd0};
    if (c_ctx == 3'd7) begin
      if (c_r < 4'd7)
        c = {4'd3, 8'd0, 3'd7 - c_r[2:0]};
      else
        c = {c_r - 4'd3, 11'd1};
    end else begin
      case ({c_ctx, c_r[2:0]})
        6'o10: c = {4'd1, 11'b1};
        6'o11: c = {4'd1, 11'b0};
        6'o20: c = {4'd1, 11'b1};
        6'o21: c = {4'd2, 11'b01};
        6'o22: c = {4'd2, 11'b00};
        6'o30: c = {4'd2, 11'b11};
        6'o31: c = {4'd2, 11'b10};
        6'o32: c = {4'd2, 11'b01};
        6'o33: c = {4'd2, 11'b00};
        6'o40: c = {4'd2, 11'b11};
        6'o41: c = {4'd2, 11'b10};
        6'o42: c = {4'd2, 11'b01};
        6'o43: c = {4'd3, 11'b001};
        6'o44: c = {4'd3, 11'b000};
        6'o50: c = {4'd2, 11'b11};
        6'o51: c = {4'd2, 11'b10};
        6'o52: c = {4'd3, 11'b011};
        6'o53: c = {4'd3, 11'b010};
        6'o54: c = {4'd3, 11'b001};
        6'o55: c = {4'd3, 11'b000};
        6'o60: c = {4'd2, 11'b11};
        6'o61: c = {4'd3, 11'b000};
        6'o62: c = {4'd3, 11'b001};
        6'o63: c = {4'd3, 11'b011};
        6'o64: c = {4'd3, 11'b010};
        6'o65: c = {4'd3, 11'b101};
        6'o66: c = {4'd3, 11'b100};
        default: ;
      endcase
    end
    return c;
  endfunction

  assign run   = runs[{idx, 2'b00} +: 4];
  assign clamp = run > zl;
  assign r     = clamp ? zl : run;
  assign ctx   = (zl > 4'd6) ? 3'd7 : zl[2:0];

  assign tz_bad   = ({2'b00, tz} + {1'b0, tc}) > 6'(MAX_COEFF);
  assign tz_cw    = tz_bad ? {4'd1, 11'd0} : tz_code(tc, tz);
  assign rb_cw    = rb_code(ctx, r);
  assign last_run = ({1'b0, idx} + 5'd1) == (tc - 5'd1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      tc    <= '0;
      tz    <= '0;
      runs  <= '0;
      zl    <= '0;
      idx   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (Start) begin
          tc   <= TotalCoeff;
          tz   <= TotalZeroes;
          runs <= RunBefore;
          err  <= 1'b0;
        end
        TOTAL_ZERO: if (hs) begin
          zl  <= tz;
          idx <= '0;
          err <= tz_bad;
        end
        ZERO_RUN: if (hs) begin
          zl  <= zl - r;
          idx <= idx + 4'd1;
          err <= err | clamp;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    CodeValid = 1'b0;
    CodeBits  = '0;
    CodeLen   = '0;
    Busy      = 1'b1;
    Done      = 1'b0;
    Err       = 1'b0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start)
          state_nxt = (TotalCoeff == 5'd0 || TotalCoeff == MAXC)
                    ? DONE : TOTAL_ZERO;
      end
      TOTAL_ZERO: begin
        CodeValid           = 1'b1;
        {CodeLen, CodeBits} = tz_cw;
        hs                  = CodeReady;
        if (CodeReady)
          state_nxt = (tz == 4'd0 || tc == 5'd1) ? DONE : ZERO_RUN;
      end
      ZERO_RUN: begin
        CodeValid           = 1'b1;
        {CodeLen, CodeBits} = rb_cw;
        hs                  = CodeReady;
        if (CodeReady)
          state_nxt = (zl == r || last_run) ? DONE : ZERO_RUN;
      end
      DONE: begin
        Done      = 1'b1;
        Err       = err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_zero_encode.sv
// tb_zero_encode: randomized blocks checked against a table-string
// model of total_zeros / run_before coding.
module tb_zero_encode;

  localparam int MAXC = 16;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [4:0]  TotalCoeff;
  logic [3:0]  TotalZeroes;
  logic [63:0] RunBefore;
  logic [10:0] CodeBits;
  logic [3:0]  CodeLen;
  logic        CodeValid;
  logic        CodeReady;
  logic        Busy;
  logic        Done;
  logic        Err;

  int n_vec = 0;
  int n_bad = 0;

  int exp_q[$];
  bit exp_err;

  zero_encode #(.MAX_COEFF(MAXC)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .TotalCoeff(TotalCoeff),
    .TotalZeroes(TotalZeroes),
    .RunBefore(RunBefore),
    .CodeBits(CodeBits),
    .CodeLen(CodeLen),
    .CodeValid(CodeValid),
    .CodeReady(CodeReady),
    .Busy(Busy),
    .Done(Done),
    .Err(Err)
  );

  always #5 Clk = ~Clk;

  // codewords as written in the standard, one string per TotalCoeff
  string tzt[15] = '{
    "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001",
    "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000",
    "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000",
    "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000",
    "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000",
    "000001 00001 111 110 101 100 011 010 0001 001 000000",
    "000001 00001 101 100 011 11 010 0001 001 000000",
    "000001 0001 00001 011 11 10 010 001 000000",
    "000001 000000 0001 11 10 001 01 00001",
    "00001 00000 001 11 10 01 0001",
    "0000 0001 001 010 1 011",
    "0000 0001 01 1 001",
    "000 001 1 01",
    "00 01 1",
    "0 1"
  };

  // run_before per zerosLeft 1..6, last entry for zerosLeft > 6
  string rbt[7] = '{
    "1 0",
    "1 01 00",
    "11 10 01 00",
    "11 10 01 001 000",
    "11 10 011 010 001 000",
    "11 000 001 011 010 101 100",
    "111 110 101 100 011 010 001 0001 00001 000001 0000001 00000001 000000001 0000000001 00000000001"
  };

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void pick(input string s, input int k,
                               output int val, output int len);
    int n;
    n = 0;
    val = 0;
    len = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == 8'h20) n++;
      else if (n == k) begin
        val = val * 2 + ((s.getc(i) == 8'h31) ? 1 : 0);
        len++;
      end
    end
  endfunction

  function automatic void build(input int tc, input int tz,
                                input logic [63:0] rb);
    int zl, r, run, v, l;
    exp_q.delete();
    exp_err = 1'b0;
    if (tc == 0 || tc == MAXC) return;
    if (tz > MAXC - tc) begin
      exp_q.push_back(1);
      exp_err = 1'b1;
    end else begin
      pick(tzt[tc-1], tz, v, l);
      exp_q.push_back(v * 16 + l);
    end
    if (tz == 0 || tc == 1) return;
    zl = tz;
    for (int i = 0; i < tc - 1; i++) begin
      run = int'(rb[4*i +: 4]);
      if (run > zl) begin
        exp_err = 1'b1;
        r = zl;
      end else r = run;
      pick(rbt[(zl > 6 ? 7 : zl) - 1], r, v, l);
      exp_q.push_back(v * 16 + l);
      zl -= r;
      if (zl == 0) break;
    end
  endfunction

  task automatic run_block(input int tc, input int tz,
                           input logic [63:0] rb,
                           input int rdy_pct, input bit poke);
    int got, cyc, n_exp;
    bit stalled, last_hs, fin;
    logic [14:0] prev;
    got = 0;
    cyc = 0;
    stalled = 0;
    last_hs = 0;
    fin = 0;
    prev = '0;
    build(tc, tz, rb);
    n_exp = exp_q.size();
    @(negedge Clk);
    Start       = 1'b1;
    TotalCoeff  = 5'(tc);
    TotalZeroes = 4'(tz);
    RunBefore   = rb;
    CodeReady   = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    if (n_exp > 0) check("first_valid", 32'(CodeValid), 1);
    else check("empty_done", 32'(Done), 1);
    while (!fin && cyc < 200) begin
      if (Done) begin
        check("code_count", got, n_exp);
        check("err", 32'(Err), 32'(exp_err));
        check("done_lag", 32'(last_hs), 32'(n_exp > 0));
        check("done_busy", 32'(Busy), 1);
        check("done_code0", {17'd0, CodeBits, CodeLen}, 0);
        Start = 1'b0;
        CodeReady = 1'b0;
        fin = 1'b1;
      end else begin
        check("busy", 32'(Busy), 1);
        check("valid", 32'(CodeValid), 1);
        if (stalled)
          check("stall_hold", {17'd0, CodeBits, CodeLen}, 32'(prev));
        CodeReady = ($urandom_range(99) < rdy_pct);
        last_hs = CodeValid && CodeReady;
        if (last_hs) begin
          check("code", {17'd0, CodeBits, CodeLen},
                got < n_exp ? exp_q[got] : -1);
          got++;
        end
        stalled = CodeValid && !CodeReady;
        prev = {CodeBits, CodeLen};
        if (poke) begin
          Start       = 1'($urandom_range(1));
          TotalCoeff  = 5'($urandom_range(16));
          TotalZeroes = 4'($urandom_range(15));
          RunBefore   = {$urandom, $urandom};
        end
      end
      @(negedge Clk);
      cyc++;
    end
    check("done_seen", 32'(fin), 1);
    Start = 1'b0;
    check("idle_busy", 32'(Busy), 0);
    check("idle_done", 32'(Done), 0);
  endtask

  task automatic rand_block();
    int tc, tz, left, run;
    logic [63:0] rb;
    tc = $urandom_range(16);
    if (tc >= 3 && $urandom_range(9) == 0)
      tz = $urandom_range(14, 17 - tc);
    else if (tc == 0 || tc == MAXC)
      tz = 0;
    else
      tz = $urandom_range(16 - tc);
    left = tz;
    rb = '0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(4) == 0) run = $urandom_range(15);
      else run = $urandom_range(left);
      rb[4*i +: 4] = 4'(run);
      left -= (run < left) ? run : left;
    end
    run_block(tc, tz, rb, $urandom_range(100, 30), 1'($urandom_range(1)));
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    CodeReady = 1'b0;
    TotalCoeff = '0;
    TotalZeroes = '0;
    RunBefore = '0;
    repeat (2) @(negedge Clk);
    check("rst_valid", 32'(CodeValid), 0);
    check("rst_code", {17'd0, CodeBits, CodeLen}, 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", {30'd0, Done, Err}, 0);
    Reset = 1'b0;

    run_block(1, 0, 64'h0, 100, 0);
    run_block(3, 2, 64'h511, 100, 0);
    run_block(2, 14, 64'hE, 100, 0);
    run_block(16, 0, 64'h0, 100, 0);
    run_block(0, 0, 64'h0, 100, 0);
    run_block(1, 15, 64'h0, 100, 0);
    repeat (10) run_block(3, 2, 64'h511, 50, 1);

    // abandon a block in ZERO_RUN
    @(negedge Clk);
    Start = 1'b1;
    TotalCoeff = 5'd3;
    TotalZeroes = 4'd2;
    RunBefore = 64'h511;
    @(negedge Clk);
    Start = 1'b0;
    CodeReady = 1'b1;
    @(negedge Clk);
    check("mid_run_code", {17'd0, CodeBits, CodeLen}, 32'h12);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    CodeReady = 1'b0;
    check("abort_valid", 32'(CodeValid), 0);
    check("abort_code", {17'd0, CodeBits, CodeLen}, 0);
    check("abort_busy", 32'(Busy), 0);
    check("abort_done", {30'd0, Done, Err}, 0);
    repeat (3) begin
      @(negedge Clk);
      check("no_done", {30'd0, Done, Busy}, 0);
    end
    run_block(3, 2, 64'h511, 100, 0);
    run_block(3, 2, 64'h3, 100, 0);

    repeat (300) rand_block();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
